dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words of storage; 2 to 65536.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request acceptance and response; 0 to 15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_fun3  input  3  RISC-V access size/sign code.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator takes the response this cycle.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  access rejected; no storage modified.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE and only while rst=1.
REQ-016 Handshake: the request is accepted on an edge with req_valid=1 and req_ready=1; the address, we, fun3 and wdata SHALL be latched at acceptance, and later input changes SHALL be ignored.
REQ-017 IDLE -> WAIT on acceptance when WAIT_CYCLES>0, loading the counter with WAIT_CYCLES-1; IDLE -> RESP on acceptance when WAIT_CYCLES=0.
REQ-018 WAIT: the counter decrements once per cycle; at counter=0, the access executes and the state moves to RESP on that edge.
REQ-019 Latency SHALL be exactly WAIT_CYCLES+1 cycles from the accepting edge to the first cycle with rsp_valid=1.
REQ-020 RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until the edge with rsp_ready=1; then RESP -> IDLE.
REQ-021 The state after a response leaves RESP SHALL be IDLE; a new request is accepted no earlier than the following cycle, so throughput is at most one request per WAIT_CYCLES+2 cycles.
REQ-022 Word index = addr[31:2]; storage is little-endian; the byte lane is selected by addr[1:0] and the halfword by addr[1].
REQ-023 Loads: fun3 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
REQ-024 Stores: fun3 000 SB uses wdata[7:0], 001 SH uses wdata[15:0], 010 SW; only the addressed bytes are written.
REQ-025 rsp_err=1 when the word index >= DEPTH_WORDS, or for an undefined fun3 (load 011/110/111; store other than 000/001/010); storage unchanged and rsp_rdata=0.
REQ-026 Storage SHALL be written only on the edge leaving WAIT, or on the accepting edge when WAIT_CYCLES=0; it is never written in RESP.
REQ-027 When the address is in range and the access is not an error, rsp_err=0.

Reset
REQ-028 While rst=0: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0; outputs change immediately, without waiting for a clock edge.
REQ-029 A reset during WAIT SHALL discard the pending access; a pending store SHALL NOT be committed.
REQ-030 A reset during RESP drops the response; the initiator SHALL NOT see rsp_valid again for that request.
REQ-031 Storage contents are not reset and are undefined until written.

Configuration
REQ-032 Macro DMEM_MISALIGN_ERR_EN when defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL give rsp_err=1, with no write and rsp_rdata=0.
REQ-033 When DMEM_MISALIGN_ERR_EN is not defined: misaligned halfword accesses SHALL force addr[0]=0 and misaligned word accesses SHALL force addr[1:0]=0; rsp_err arises only from REQ-025.

Verification
REQ-034 WAIT_CYCLES=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid in the 3rd cycle after acceptance, rdata=0xDEADBEEF, err=0.
REQ-035 After REQ-034: SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
REQ-036 Hold rsp_ready=0 for 5 cycles during a response -> rsp_valid, rdata and err stable and req_ready=0 throughout; a single accept follows rsp_ready=1.
REQ-037 LW addr 4*DEPTH_WORDS -> err=1, rdata=0; store fun3=011 -> err=1 and the target word is unchanged.
REQ-038 LH addr 0x13: with DMEM_MISALIGN_ERR_EN -> err=1; without -> returns the halfword at 0x12, sign-extended.
REQ-039 Accept SW 0x20 data 0x12345678, assert rst=0 in WAIT, release, then LW 0x20 -> not 0x12345678 (prefill 0x0 beforehand, expect 0x0).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed wait states, held response.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned halfword/word accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_fun3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [2:0]  lat_fun3;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        exec;
  logic        wr_en;
  logic        op_we;
  logic [31:0] op_addr;
  logic [2:0]  op_fun3;
  logic [31:0] op_wdata;
  logic        in_range;
  logic        bad_fun3;
  logic        misal;
  logic        op_err;
  logic [1:0]  off;
  logic [31:0] cur_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_data;
  logic [31:0] wr_mask;
  logic [31:0] wr_data;
  logic [31:0] new_word;
  logic [AW-1:0] idx;

  assign req_ready = rst && (state == IDLE);
  assign accept    = req_valid && req_ready;

  // With no wait states the access runs on the accepting edge
  // straight from the request inputs.
  assign op_we    = (WAIT_CYCLES == 0) ? req_we    : lat_we;
  assign op_addr  = (WAIT_CYCLES == 0) ? req_addr  : lat_addr;
  assign op_fun3  = (WAIT_CYCLES == 0) ? req_fun3  : lat_fun3;
  assign op_wdata = (WAIT_CYCLES == 0) ? req_wdata : lat_wdata;

  assign exec = (WAIT_CYCLES == 0) ? accept
              : (state == WAIT) && (cnt == 4'd0);

  assign idx      = op_addr[AW+1:2];
  assign cur_word = mem[idx];

`ifdef DMEM_MISALIGN_ERR_EN
  assign misal = ((op_fun3[1:0] == 2'b01) && op_addr[0]) ||
                 ((op_fun3[1:0] == 2'b10) && (|op_addr[1:0]));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    in_range = {2'b00, op_addr[31:2]} < 32'(DEPTH_WORDS);
    unique case (op_fun3)
      3'b000, 3'b001, 3'b010: bad_fun3 = 1'b0;
      3'b100, 3'b101:         bad_fun3 = op_we;
      default:                bad_fun3 = 1'b1;
    endcase
    op_err = !in_range || bad_fun3 || misal;
    off[1] = op_addr[1] & ~op_fun3[1];
    off[0] = op_addr[0] & (op_fun3[1:0] == 2'b00);
  end

  always_comb begin
    rd_byte = 8'(cur_word >> {off, 3'b000});
    rd_half = 16'(cur_word >> {off[1], 4'b0000});
    unique case (op_fun3)
      3'b000:  rd_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_data = cur_word;
      3'b100:  rd_data = {24'd0, rd_byte};
      3'b101:  rd_data = {16'd0, rd_half};
      default: rd_data = 32'd0;
    endcase
    if (op_err || op_we) rd_data = 32'd0;
  end

  always_comb begin
    unique case (op_fun3[1:0])
      2'b00: begin
        wr_mask = 32'h0000_00ff << {off, 3'b000};
        wr_data = {24'd0, op_wdata[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        wr_mask = 32'h0000_ffff << {off[1], 4'b0000};
        wr_data = {16'd0, op_wdata[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        wr_mask = 32'hffff_ffff;
        wr_data = op_wdata;
      end
    endcase
    new_word = (cur_word & ~wr_mask) | (wr_data & wr_mask);
  end

  assign wr_en = exec && op_we && !op_err;

  // Storage has no reset; a reset clears state so no write can follow.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= new_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_fun3  <= 3'd0;
      lat_wdata <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_fun3  <= req_fun3;
            lat_wdata <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_data;
              rsp_err   <= op_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_data;
            rsp_err   <= op_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
